// File: rtl/param_shift_reg_if.sv
// Bus bundle for param_shift_reg: control, serial/parallel data in, stage image and fill status out.
// The o_parity signal exists only when SHIFT_PARITY_EN is defined.
interface param_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int FW = $clog2(DEPTH + 1)
) ();

  logic                   i_en;
  logic                   i_clear;
  logic [1:0]             i_mode;
  logic [WIDTH-1:0]       i_din;
  logic [WIDTH*DEPTH-1:0] i_load_data;
  logic [WIDTH*DEPTH-1:0] o_q;
  logic [WIDTH-1:0]       o_dout;
  logic [FW-1:0]          o_fill;
  logic                   o_full;
`ifdef SHIFT_PARITY_EN
  logic                   o_parity;

  modport master (
    output i_en, i_clear, i_mode, i_din, i_load_data,
    input  o_q, o_dout, o_fill, o_full, o_parity
  );

  modport slave (
    input  i_en, i_clear, i_mode, i_din, i_load_data,
    output o_q, o_dout, o_fill, o_full, o_parity
  );
`else
  modport master (
    output i_en, i_clear, i_mode, i_din, i_load_data,
    input  o_q, o_dout, o_fill, o_full
  );

  modport slave (
    input  i_en, i_clear, i_mode, i_din, i_load_data,
    output o_q, o_dout, o_fill, o_full
  );
`endif

endinterface

// File: rtl/param_shift_reg.sv
// WIDTH x DEPTH shift register with hold / shift / rotate / parallel load, sync clear and fill tracking.
// Define SHIFT_PARITY_EN to add o_parity, the XOR of every stage bit.
module param_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  param_shift_reg_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam logic [FW-1:0] FULL_COUNT = FW'(DEPTH);

  logic [WIDTH-1:0]       r_stage [DEPTH];
  logic [FW-1:0]          r_fill;
  logic [WIDTH-1:0]       w_next_stage [DEPTH];
  logic [FW-1:0]          w_next_fill;
  logic [WIDTH*DEPTH-1:0] w_q;
  mode_e                  w_mode;

  assign w_mode = mode_e'(bus.i_mode);

  // Every next value is built from the current registers only, so all stages move together.
  always_comb begin
    w_next_stage = r_stage;
    w_next_fill  = r_fill;
    if (bus.i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_next_stage[i] = '0;
      end
      w_next_fill = '0;
    end else if (bus.i_en) begin
      case (w_mode)
        MODE_HOLD: begin
        end
        MODE_SHIFT: begin
          w_next_stage[0] = bus.i_din;
          for (int i = 1; i < DEPTH; i++) begin
            w_next_stage[i] = r_stage[i-1];
          end
          if (r_fill != FULL_COUNT) begin
            w_next_fill = r_fill + FW'(1);
          end
        end
        MODE_ROTATE: begin
          w_next_stage[0] = r_stage[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) begin
            w_next_stage[i] = r_stage[i-1];
          end
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            w_next_stage[i] = bus.i_load_data[(DEPTH-1-i)*WIDTH +: WIDTH];
          end
          w_next_fill = FULL_COUNT;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
    end else begin
      r_stage <= w_next_stage;
      r_fill  <= w_next_fill;
    end
  end

  // Stage 0 lands in the most significant slice of q.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_q[(DEPTH-1-i)*WIDTH +: WIDTH] = r_stage[i];
    end
  end

  assign bus.o_q    = w_q;
  assign bus.o_dout = r_stage[DEPTH-1];
  assign bus.o_fill = r_fill;
  assign bus.o_full = (r_fill == FULL_COUNT);

`ifdef SHIFT_PARITY_EN
  assign bus.o_parity = ^w_q;
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg: a 1x4 and an 8x3 instance against a vector-level model.
// Parity checks are included when SHIFT_PARITY_EN is defined.
module tb_param_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_shift_reg_if #(.WIDTH(1), .DEPTH(4)) ifA ();
  param_shift_reg_if #(.WIDTH(8), .DEPTH(3)) ifB ();

  param_shift_reg #(.WIDTH(1), .DEPTH(4)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  param_shift_reg #(.WIDTH(8), .DEPTH(3)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: whole register image as one vector, s0 at the top; shift moves everything down one slice.
  logic [3:0]  mA_q;
  int          mA_fill;
  logic [23:0] mB_q;
  int          mB_fill;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA_q    <= '0;
      mA_fill <= 0;
      mB_q    <= '0;
      mB_fill <= 0;
    end else begin
      if (ifA.i_clear) begin
        mA_q    <= '0;
        mA_fill <= 0;
      end else if (ifA.i_en) begin
        case (ifA.i_mode)
          2'b01: begin
            mA_q    <= {ifA.i_din, mA_q[3:1]};
            mA_fill <= (mA_fill < 4) ? mA_fill + 1 : 4;
          end
          2'b10: mA_q <= {mA_q[0], mA_q[3:1]};
          2'b11: begin
            mA_q    <= ifA.i_load_data;
            mA_fill <= 4;
          end
          default: begin
          end
        endcase
      end
      if (ifB.i_clear) begin
        mB_q    <= '0;
        mB_fill <= 0;
      end else if (ifB.i_en) begin
        case (ifB.i_mode)
          2'b01: begin
            mB_q    <= {ifB.i_din, mB_q[23:8]};
            mB_fill <= (mB_fill < 3) ? mB_fill + 1 : 3;
          end
          2'b10: mB_q <= {mB_q[7:0], mB_q[23:8]};
          2'b11: begin
            mB_q    <= ifB.i_load_data;
            mB_fill <= 3;
          end
          default: begin
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model-vs-DUT comparison on every falling edge outside reset.
  always @(negedge clk) begin
    if (started && !rst) begin
      checkOutput("A.q",    32'(ifA.o_q),    32'(mA_q));
      checkOutput("A.dout", 32'(ifA.o_dout), 32'(mA_q[0]));
      checkOutput("A.fill", 32'(ifA.o_fill), 32'(mA_fill));
      checkOutput("A.full", 32'(ifA.o_full), 32'(mA_fill == 4));
      checkOutput("B.q",    32'(ifB.o_q),    32'(mB_q));
      checkOutput("B.dout", 32'(ifB.o_dout), 32'(mB_q[7:0]));
      checkOutput("B.fill", 32'(ifB.o_fill), 32'(mB_fill));
      checkOutput("B.full", 32'(ifB.o_full), 32'(mB_fill == 3));
`ifdef SHIFT_PARITY_EN
      checkOutput("A.parity", 32'(ifA.o_parity), 32'(^mA_q));
      checkOutput("B.parity", 32'(ifB.o_parity), 32'(^mB_q));
`endif
    end
  end

  task automatic applyStimulusA(input logic e, input logic c, input logic [1:0] m,
                                input logic d, input logic [3:0] ld);
    @(negedge clk);
    ifA.i_en        = e;
    ifA.i_clear     = c;
    ifA.i_mode      = m;
    ifA.i_din       = d;
    ifA.i_load_data = ld;
    ifB.i_en        = 1'b0;
    ifB.i_clear     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusB(input logic e, input logic c, input logic [1:0] m,
                                input logic [7:0] d, input logic [23:0] ld);
    @(negedge clk);
    ifB.i_en        = e;
    ifB.i_clear     = c;
    ifB.i_mode      = m;
    ifB.i_din       = d;
    ifB.i_load_data = ld;
    ifA.i_en        = 1'b0;
    ifA.i_clear     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] SHIFT_IN [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    ifA.i_en = 1'b0; ifA.i_clear = 1'b0; ifA.i_mode = 2'b00; ifA.i_din = '0; ifA.i_load_data = '0;
    ifB.i_en = 1'b0; ifB.i_clear = 1'b0; ifB.i_mode = 2'b00; ifB.i_din = '0; ifB.i_load_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.A.q",    32'(ifA.o_q),    0);
    checkOutput("rst.A.fill", 32'(ifA.o_fill), 0);
    checkOutput("rst.A.full", 32'(ifA.o_full), 0);
    checkOutput("rst.B.q",    32'(ifB.o_q),    0);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Serial fill 1,0,1,1 then one more shift on a full register
    for (int i = 0; i < 4; i++) begin
      applyStimulusA(1'b1, 1'b0, 2'b01, SHIFT_IN[i][0], 4'h0);
      checkOutput($sformatf("shift.fill%0d", i + 1), 32'(ifA.o_fill), 32'(i + 1));
    end
    checkOutput("shift4.q",    32'(ifA.o_q),    32'h0000000D);
    checkOutput("shift4.dout", 32'(ifA.o_dout), 1);
    checkOutput("shift4.full", 32'(ifA.o_full), 1);
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b0, 4'h0);
    checkOutput("shift5.q",    32'(ifA.o_q),    32'h00000006);
    checkOutput("shift5.fill", 32'(ifA.o_fill), 4);

    // Rotate from 1101
    applyStimulusA(1'b1, 1'b0, 2'b11, 1'b0, 4'b1101);
    checkOutput("load1101.q", 32'(ifA.o_q), 32'h0000000D);
`ifdef SHIFT_PARITY_EN
    checkOutput("load1101.parity", 32'(ifA.o_parity), 1);
`endif
    applyStimulusA(1'b1, 1'b0, 2'b10, 1'b0, 4'h0);
    checkOutput("rot1.q",    32'(ifA.o_q),    32'h0000000E);
    checkOutput("rot1.fill", 32'(ifA.o_fill), 4);
`ifdef SHIFT_PARITY_EN
    checkOutput("rot1.parity", 32'(ifA.o_parity), 1);
`endif
    for (int i = 0; i < 3; i++) applyStimulusA(1'b1, 1'b0, 2'b10, 1'b0, 4'h0);
    checkOutput("rot4.q", 32'(ifA.o_q), 32'h0000000D);
    applyStimulusA(1'b1, 1'b0, 2'b11, 1'b0, 4'b1001);
    checkOutput("load1001.q", 32'(ifA.o_q), 32'h00000009);
`ifdef SHIFT_PARITY_EN
    checkOutput("load1001.parity", 32'(ifA.o_parity), 0);
`endif
    applyStimulusA(1'b1, 1'b0, 2'b00, 1'b1, 4'hF);
    checkOutput("hold.q", 32'(ifA.o_q), 32'h00000009);

    // Wide instance: load, then disabled shifts, then a shift while full
    applyStimulusB(1'b1, 1'b0, 2'b11, 8'h00, 24'hA1B2C3);
    checkOutput("B.load.q",    32'(ifB.o_q),    32'h00A1B2C3);
    checkOutput("B.load.dout", 32'(ifB.o_dout), 32'h000000C3);
    checkOutput("B.load.fill", 32'(ifB.o_fill), 3);
    for (int i = 0; i < 5; i++) applyStimulusB(1'b0, 1'b0, 2'b01, 8'hFF, 24'h0);
    checkOutput("B.en0.q",    32'(ifB.o_q),    32'h00A1B2C3);
    checkOutput("B.en0.fill", 32'(ifB.o_fill), 3);
    applyStimulusB(1'b1, 1'b0, 2'b01, 8'hFF, 24'h0);
    checkOutput("B.shiftfull.q",    32'(ifB.o_q),    32'h00FFA1B2);
    checkOutput("B.shiftfull.dout", 32'(ifB.o_dout), 32'h000000B2);
    checkOutput("B.shiftfull.fill", 32'(ifB.o_fill), 3);

    // Clear with en=0, refill partly, then clear beating a load
    applyStimulusA(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
    checkOutput("clr.q",    32'(ifA.o_q),    0);
    checkOutput("clr.fill", 32'(ifA.o_fill), 0);
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b1, 4'h0);
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b1, 4'h0);
    checkOutput("part.q",    32'(ifA.o_q),    32'h0000000C);
    checkOutput("part.fill", 32'(ifA.o_fill), 2);
    applyStimulusA(1'b1, 1'b1, 2'b11, 1'b0, 4'hF);
    checkOutput("clrwin.q",    32'(ifA.o_q),    0);
    checkOutput("clrwin.fill", 32'(ifA.o_fill), 0);
    checkOutput("clrwin.full", 32'(ifA.o_full), 0);

    // Rotate while partially filled keeps fill
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b1, 4'h0);
    applyStimulusA(1'b1, 1'b0, 2'b10, 1'b0, 4'h0);
    checkOutput("partrot.q",    32'(ifA.o_q),    32'h00000004);
    checkOutput("partrot.fill", 32'(ifA.o_fill), 1);

    // Asynchronous reset pulse between edges
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b1, 4'h0);
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b0, 4'h0);
    @(negedge clk);
    ifA.i_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.q",    32'(ifA.o_q),    0);
    checkOutput("arst.dout", 32'(ifA.o_dout), 0);
    checkOutput("arst.fill", 32'(ifA.o_fill), 0);
    checkOutput("arst.full", 32'(ifA.o_full), 0);
    checkOutput("arst.B.q",  32'(ifB.o_q),    0);
    #1 rst = 1'b0;
    applyStimulusA(1'b1, 1'b0, 2'b01, 1'b1, 4'h0);
    checkOutput("postrst.q",    32'(ifA.o_q),    32'h00000008);
    checkOutput("postrst.fill", 32'(ifA.o_fill), 1);

    applyStimulusA(1'b0, 1'b0, 2'b00, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised successor to the fixed 4-stage, 1-bit serial shift register family.
- WIDTH-bit samples move through DEPTH registered stages.
- Runtime modes: hold, shift, rotate and parallel load, with a synchronous clear.
- Tracks how many stages hold valid data; serves as a generic delay line / SIPO / PISO primitive and as a differential-testing target against the legacy shift designs.

Parameters:
- WIDTH, 1, bits per stage; must be >= 1.
- DEPTH, 4, number of stages; must be >= 2.
- FW, $clog2(DEPTH+1), width of fill count; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0 the mode is ignored (clear still acts).
- clear  input  1  synchronous clear; highest priority after rst.
- mode  input  2  00 hold, 01 shift, 10 rotate, 11 parallel load.
- din  input  WIDTH  serial sample entering stage 0 on shift.
- load_data  input  WIDTH*DEPTH  parallel image, same packing as q.
- q  output  WIDTH*DEPTH  all stages, packed as {s0, s1, ..., s(DEPTH-1)}; s0 is the most significant slice.
- dout  output  WIDTH  s(DEPTH-1), the oldest stage.
- fill  output  FW  number of valid stages, 0..DEPTH.
- full  output  1  fill == DEPTH.
- parity  output  1  present only with SHIFT_PARITY_EN.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-high.
- All state is in flops; q, dout, fill and full are direct register outputs or decodes of registers. Data visible the cycle after the capturing edge, i.e. 1-cycle latency per stage.
- rst=1: all stages, fill and full go to 0 immediately, independent of clk, and stay there while rst is high.
- Per rising edge, priority order:
  1. clear=1 -> all stages 0, fill 0 (regardless of en/mode).
  2. en=0 -> all state held.
  3. mode 00 hold -> state held.
  4. mode 01 shift -> s0<=din, s(i)<=s(i-1) for i>=1, old s(DEPTH-1) discarded. fill<=fill+1, saturating at DEPTH.
  5. mode 10 rotate -> s0<=s(DEPTH-1), s(i)<=s(i-1). fill unchanged.
  6. mode 11 load -> stages <= load_data (same packing as q). fill<=DEPTH.
- All stage updates in one edge are simultaneous (non-blocking semantics). No stage observes a same-edge update of another stage.
- full = (fill == DEPTH), decoded from the fill register.
- Shift on a full register keeps fill=DEPTH and full=1.
- Rotate on a partially filled register rotates zeros/invalid stages too; fill unchanged.
- Deasserting rst between edges: first edge after release operates normally.

Optional Feature:
- Macro SHIFT_PARITY_EN.
- Defined: adds output parity = XOR reduction of all WIDTH*DEPTH stage bits. Combinational from the stage registers, so it is valid in the same cycle as q. Value is 0 in reset.
- Undefined: parity port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1, DEPTH=4, en=1, mode=01, din sequence 1,0,1,1 over 4 edges -> q=4'b1101, dout=1, fill 1,2,3,4, full=1 after the 4th edge; a 5th shift with din=0 -> q=4'b0110, fill stays 4.
- From q=4'b1101, mode=10 for one edge -> q=4'b1110, fill unchanged. Four rotates in total -> q returns to 4'b1101.
- WIDTH=8, DEPTH=3, mode=11, load_data=24'hA1B2C3 -> q=24'hA1B2C3, dout=8'hC3, fill=3. Then en=0 with mode=01, din=8'hFF for 5 edges -> q unchanged.
- Partially filled (fill=2): assert clear together with en=1, mode=11 -> q=0, fill=0, full=0 (clear wins).
- Mid-stream, pulse rst between clock edges -> q, dout, fill, full read 0 before the next edge. After release, one shift with din=1 (WIDTH=1, DEPTH=4) -> q=4'b1000, fill=1.
- With SHIFT_PARITY_EN, WIDTH=1, DEPTH=4: q=4'b1101 -> parity=1; q=4'b1110 after rotate -> parity=1; load 4'b1001 -> parity=0.
